hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline control unit for the 5-stage RV32I core.
- Sequences fetch, decode and execute stage enables: drives fetch/decode stall and flush, the execute bubble and the execute stall.
- Detects load-use hazards on the decoder's rs1/rs2 outputs, holds the pipe during data-memory waits, and runs multi-cycle flushes with PC redirect on taken branch/jump or trap.
- Sits beside decoder_stage; its outputs feed the ds_i_stall/ds_i_flush style inputs of each stage.

Parameters:
AWIDTH, 5, register address width
PC_WIDTH, 32, program counter width
FLUSH_CYCLES, 2, cycles fetch/decode flush stays asserted after a redirect (>=1)
CNT_WIDTH, 32, performance counter width

Ports:
hc_clk  in  1  clock, rising edge
hc_rst  in  1  synchronous reset, active-high
hc_i_ds_valid  in  1  decode stage holds a valid instruction
hc_i_ds_rs1  in  AWIDTH  rs1 address from decode
hc_i_ds_rs2  in  AWIDTH  rs2 address from decode
hc_i_ex_valid  in  1  execute stage holds a valid instruction
hc_i_ex_is_load  in  1  execute instruction is a load
hc_i_ex_rd  in  AWIDTH  execute destination register
hc_i_br_taken  in  1  execute resolved a taken branch/jump
hc_i_br_target  in  PC_WIDTH  branch/jump target
hc_i_trap  in  1  decode raised an exception
hc_i_trap_vec  in  PC_WIDTH  trap handler address
hc_i_mem_busy  in  1  data memory not ready
hc_o_fs_stall  out  1  hold fetch
hc_o_fs_flush  out  1  kill fetch output
hc_o_ds_stall  out  1  hold decode
hc_o_ds_flush  out  1  kill decode output
hc_o_ex_stall  out  1  hold execute
hc_o_ex_bubble  out  1  inject NOP into execute
hc_o_redirect  out  1  one-cycle PC redirect strobe
hc_o_redirect_pc  out  PC_WIDTH  new PC, valid with hc_o_redirect
hc_o_state  out  2  current FSM state
hc_o_cnt_lu  out  CNT_WIDTH  load-use stall cycles
hc_o_cnt_mw  out  CNT_WIDTH  mem-wait cycles
hc_o_cnt_fl  out  CNT_WIDTH  redirect events

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2. Flush counter fl_cnt is sized for FLUSH_CYCLES.
- Reset: state=RUN, fl_cnt=0, counters=0. While hc_rst=1 all outputs are 0 and redirect_pc=0.
- Outputs are combinational from state and inputs; there is no added latency.
- Priority in RUN: trap > br_taken > mem_busy > load-use.
- Load-use condition: ds_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2).
- Load-use response: in RUN, assert fs_stall, ds_stall and ex_bubble for that cycle only. State stays RUN. The next cycle the load has left execute, so the condition clears naturally.
- Trap in RUN:
  - redirect=1, redirect_pc=trap_vec, fs_flush=ds_flush=1.
  - If FLUSH_CYCLES>1: next state FLUSH, fl_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- br_taken in RUN: identical to trap but redirect_pc=br_target. Trap wins when both are high; br_target is dropped.
- mem_busy in RUN (no trap/branch):
  - Assert fs_stall, ds_stall and ex_stall.
  - Next state MEM_WAIT.
- MEM_WAIT:
  - fs_stall, ds_stall and ex_stall stay 1 while mem_busy=1.
  - br_taken, trap and load-use are ignored.
  - When mem_busy=0, stalls drop in that same cycle and next state is RUN. That cycle's br/trap are evaluated as in RUN.
- FLUSH:
  - fs_flush=ds_flush=1 and fl_cnt decrements.
  - At fl_cnt==1, next state is RUN.
  - mem_busy in FLUSH also asserts the three stalls, and fl_cnt holds.
  - A new trap or br_taken in FLUSH restarts the flush: new redirect, fl_cnt reloaded.
- A load-use is never signalled in the same cycle as a flush of decode.
- Reset mid-FLUSH or mid-MEM_WAIT returns to RUN the next edge with all outputs 0.

Optional Feature:
HC_PERF_CNT_EN
- Defined: the three counters increment on load-use stall cycles, MEM_WAIT/stall cycles, and redirect strobes respectively. They wrap at 2^CNT_WIDTH and clear on reset.
- Undefined: counter logic is not built; hc_o_cnt_* are tied to 0. Ports always exist.

Decomposition:
- Shared header hazard_defs.v holds the `HC_STATE_WIDTH define and the `HC_RUN/`HC_MEM_WAIT/`HC_FLUSH state encodings. It sits alongside the existing ALU/opcode/exception defines.
- One sub-module, hc_load_use_detect: purely combinational comparator producing the load-use condition.

Test Plan:
- Load-use: ex load rd=5, ds rs1=5, both valid -> fs_stall=ds_stall=ex_bubble=1 for exactly 1 cycle, state stays 0. Repeat with rd=0 -> no stall.
- Branch: br_taken=1, br_target=0x100, FLUSH_CYCLES=2 -> redirect=1 with pc=0x100 for 1 cycle; fs_flush/ds_flush high 2 cycles; then state=RUN.
- Trap+branch same cycle: trap_vec=0x80, br_target=0x100 -> redirect_pc=0x80 only.
- Mem wait: mem_busy high 3 cycles -> three stalls high 3 cycles, state=1. They drop the cycle busy falls. A br_taken asserted during busy produces no redirect.
- Reset mid-flush: assert hc_rst during FLUSH -> next edge state=0, all outputs 0, counters 0.
- With HC_PERF_CNT_EN: two load-use stalls, 3 mem-wait cycles, 1 branch -> cnt_lu=2, cnt_mw=3, cnt_fl=1. Without the macro all read 0.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// state width and the flush-counter sizing helper.
package hazard_controller_pkg;

  localparam int HC_STATE_WIDTH = 2;

  // RUN=0, MEM_WAIT=1, FLUSH=2; exposed unchanged on hc_o_state.
  typedef enum logic [HC_STATE_WIDTH-1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_FLUSH    = 2'd2
  } hc_state_e;

  // Bits needed to hold FLUSH_CYCLES-1, never less than one bit.
  function automatic int hc_fl_width(input int flush_cycles);
    return (flush_cycles > 1) ? $clog2(flush_cycles) : 1;
  endfunction

endpackage

// File: rtl/hc_load_use_detect.sv
// Load-use comparator: flags a decode instruction that reads the destination
// of a load still sitting in execute. x0 never creates a hazard.
module hc_load_use_detect
  import hazard_controller_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              i_ds_valid,
  input  logic [AWIDTH-1:0] i_ds_rs1,
  input  logic [AWIDTH-1:0] i_ds_rs2,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic [AWIDTH-1:0] i_ex_rd,
  output logic              o_hazard
);

  logic w_rd_nonzero;
  logic w_rd_match;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rd_match   = (i_ex_rd == i_ds_rs1) | (i_ex_rd == i_ds_rs2);
  assign o_hazard     = i_ds_valid & i_ex_valid & i_ex_is_load & w_rd_nonzero & w_rd_match;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use bubbles,
// data-memory wait stalls and multi-cycle redirect flushes.
// Optional macro HC_PERF_CNT_EN builds the three performance counters;
// without it hc_o_cnt_* read 0.
//
// Handshake: hc_i_mem_busy is the inverted ready of the data memory. While it
// is high the execute stage cannot retire, so fetch/decode/execute are held
// combinationally in that same cycle; the pipe advances in the first cycle it
// is low.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ds_valid,
  input  logic [AWIDTH-1:0]    hc_i_ds_rs1,
  input  logic [AWIDTH-1:0]    hc_i_ds_rs2,
  input  logic                 hc_i_ex_valid,
  input  logic                 hc_i_ex_is_load,
  input  logic [AWIDTH-1:0]    hc_i_ex_rd,
  input  logic                 hc_i_br_taken,
  input  logic [PC_WIDTH-1:0]  hc_i_br_target,
  input  logic                 hc_i_trap,
  input  logic [PC_WIDTH-1:0]  hc_i_trap_vec,
  input  logic                 hc_i_mem_busy,
  output logic                 hc_o_fs_stall,
  output logic                 hc_o_fs_flush,
  output logic                 hc_o_ds_stall,
  output logic                 hc_o_ds_flush,
  output logic                 hc_o_ex_stall,
  output logic                 hc_o_ex_bubble,
  output logic                 hc_o_redirect,
  output logic [PC_WIDTH-1:0]  hc_o_redirect_pc,
  output logic [1:0]           hc_o_state,
  output logic [CNT_WIDTH-1:0] hc_o_cnt_lu,
  output logic [CNT_WIDTH-1:0] hc_o_cnt_mw,
  output logic [CNT_WIDTH-1:0] hc_o_cnt_fl
);

  localparam int             FLW         = hc_fl_width(FLUSH_CYCLES);
  localparam logic [FLW-1:0] FL_RELOAD   = FLW'(FLUSH_CYCLES - 1);
  localparam logic [FLW-1:0] FL_ONE      = FLW'(1);
  localparam bit             MULTI_FLUSH = (FLUSH_CYCLES > 1);

  hc_state_e           r_state;
  hc_state_e           w_state_nxt;
  logic [FLW-1:0]      r_fl_cnt;
  logic [FLW-1:0]      w_fl_cnt_nxt;
  logic                w_lu_hazard;
  logic                w_redir_req;
  logic [PC_WIDTH-1:0] w_redir_pc_sel;
  logic                w_fs_stall;
  logic                w_fs_flush;
  logic                w_ds_stall;
  logic                w_ds_flush;
  logic                w_ex_stall;
  logic                w_ex_bubble;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_redirect_pc;
  logic                w_lu_stall;

  hc_load_use_detect #(
    .AWIDTH(AWIDTH)
  ) u_lu_detect (
    .i_ds_valid  (hc_i_ds_valid),
    .i_ds_rs1    (hc_i_ds_rs1),
    .i_ds_rs2    (hc_i_ds_rs2),
    .i_ex_valid  (hc_i_ex_valid),
    .i_ex_is_load(hc_i_ex_is_load),
    .i_ex_rd     (hc_i_ex_rd),
    .o_hazard    (w_lu_hazard)
  );

  // Trap outranks a taken branch; the branch target is dropped when both fire.
  assign w_redir_req    = hc_i_trap | hc_i_br_taken;
  assign w_redir_pc_sel = hc_i_trap ? hc_i_trap_vec : hc_i_br_target;

  // Next-state and stage-control decode; everything is forced low during reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_fl_cnt_nxt  = r_fl_cnt;
    w_fs_stall    = 1'b0;
    w_fs_flush    = 1'b0;
    w_ds_stall    = 1'b0;
    w_ds_flush    = 1'b0;
    w_ex_stall    = 1'b0;
    w_ex_bubble   = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_lu_stall    = 1'b0;
    case (r_state)
      HC_RUN: begin
        if (w_redir_req) begin
          w_redirect    = 1'b1;
          w_redirect_pc = w_redir_pc_sel;
          w_fs_flush    = 1'b1;
          w_ds_flush    = 1'b1;
          if (MULTI_FLUSH) begin
            w_state_nxt  = HC_FLUSH;
            w_fl_cnt_nxt = FL_RELOAD;
          end
        end else if (hc_i_mem_busy) begin
          w_fs_stall  = 1'b1;
          w_ds_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_state_nxt = HC_MEM_WAIT;
        end else if (w_lu_hazard) begin
          w_fs_stall  = 1'b1;
          w_ds_stall  = 1'b1;
          w_ex_bubble = 1'b1;
          w_lu_stall  = 1'b1;
        end
      end
      HC_MEM_WAIT: begin
        if (hc_i_mem_busy) begin
          w_fs_stall = 1'b1;
          w_ds_stall = 1'b1;
          w_ex_stall = 1'b1;
        end else begin
          // Memory released: this cycle behaves like RUN for redirects only.
          w_state_nxt = HC_RUN;
          if (w_redir_req) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_redir_pc_sel;
            w_fs_flush    = 1'b1;
            w_ds_flush    = 1'b1;
            if (MULTI_FLUSH) begin
              w_state_nxt  = HC_FLUSH;
              w_fl_cnt_nxt = FL_RELOAD;
            end
          end
        end
      end
      HC_FLUSH: begin
        w_fs_flush = 1'b1;
        w_ds_flush = 1'b1;
        if (w_redir_req) begin
          w_redirect    = 1'b1;
          w_redirect_pc = w_redir_pc_sel;
          w_fl_cnt_nxt  = FL_RELOAD;
        end else if (hc_i_mem_busy) begin
          w_fs_stall = 1'b1;
          w_ds_stall = 1'b1;
          w_ex_stall = 1'b1;
        end else begin
          w_fl_cnt_nxt = r_fl_cnt - FL_ONE;
          if (r_fl_cnt == FL_ONE) begin
            w_state_nxt = HC_RUN;
          end
        end
      end
      default: begin
        w_state_nxt  = HC_RUN;
        w_fl_cnt_nxt = '0;
      end
    endcase
    if (hc_rst) begin
      w_fs_stall    = 1'b0;
      w_fs_flush    = 1'b0;
      w_ds_stall    = 1'b0;
      w_ds_flush    = 1'b0;
      w_ex_stall    = 1'b0;
      w_ex_bubble   = 1'b0;
      w_redirect    = 1'b0;
      w_redirect_pc = '0;
      w_lu_stall    = 1'b0;
    end
  end

  // State and flush-countdown registers.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      r_state  <= HC_RUN;
      r_fl_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
    end
  end

  assign hc_o_fs_stall    = w_fs_stall;
  assign hc_o_fs_flush    = w_fs_flush;
  assign hc_o_ds_stall    = w_ds_stall;
  assign hc_o_ds_flush    = w_ds_flush;
  assign hc_o_ex_stall    = w_ex_stall;
  assign hc_o_ex_bubble   = w_ex_bubble;
  assign hc_o_redirect    = w_redirect;
  assign hc_o_redirect_pc = w_redirect_pc;
  assign hc_o_state       = hc_rst ? 2'd0 : r_state;

`ifdef HC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt_lu;
  logic [CNT_WIDTH-1:0] r_cnt_mw;
  logic [CNT_WIDTH-1:0] r_cnt_fl;

  // Free-running wrap-around event counters.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      r_cnt_lu <= '0;
      r_cnt_mw <= '0;
      r_cnt_fl <= '0;
    end else begin
      if (w_lu_stall) r_cnt_lu <= r_cnt_lu + CNT_WIDTH'(1);
      if (w_ex_stall) r_cnt_mw <= r_cnt_mw + CNT_WIDTH'(1);
      if (w_redirect) r_cnt_fl <= r_cnt_fl + CNT_WIDTH'(1);
    end
  end

  assign hc_o_cnt_lu = hc_rst ? '0 : r_cnt_lu;
  assign hc_o_cnt_mw = hc_rst ? '0 : r_cnt_mw;
  assign hc_o_cnt_fl = hc_rst ? '0 : r_cnt_fl;
`else
  assign hc_o_cnt_lu = '0;
  assign hc_o_cnt_mw = '0;
  assign hc_o_cnt_fl = '0;
`endif

endmodule
